// File: rtl/mp_multicycle_core_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mp_pkg
// Purpose  : Shared opcodes, ALU function codes, FSM states and instruction
//            field positions for the MP multicycle core.
// Revision : 1.0 - initial release
// ============================================================================
package mp_pkg;

    localparam logic [3:0] OP_RALU = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_LW   = 4'h2;
    localparam logic [3:0] OP_SW   = 4'h3;
    localparam logic [3:0] OP_BEQ  = 4'h4;
    localparam logic [3:0] OP_BNE  = 4'h5;
    localparam logic [3:0] OP_J    = 4'h6;
    localparam logic [3:0] OP_JAL  = 4'h7;
    localparam logic [3:0] OP_JR   = 4'h8;
    localparam logic [3:0] OP_IN   = 4'h9;
    localparam logic [3:0] OP_OUT  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hB;

    localparam logic [2:0] FN_ADD = 3'd0;
    localparam logic [2:0] FN_SUB = 3'd1;
    localparam logic [2:0] FN_AND = 3'd2;
    localparam logic [2:0] FN_OR  = 3'd3;
    localparam logic [2:0] FN_XOR = 3'd4;
    localparam logic [2:0] FN_SLT = 3'd5;
    localparam logic [2:0] FN_SHL = 3'd6;
    localparam logic [2:0] FN_SHR = 3'd7;

    localparam logic [2:0] LINK_REG = 3'd7;

    localparam int OP_MSB    = 15;
    localparam int OP_LSB    = 12;
    localparam int RS_MSB    = 11;
    localparam int RS_LSB    = 9;
    localparam int RT_MSB    = 8;
    localparam int RT_LSB    = 6;
    localparam int RD_MSB    = 5;
    localparam int RD_LSB    = 3;
    localparam int FN_MSB    = 2;
    localparam int FN_LSB    = 0;
    localparam int IMM6_MSB  = 5;
    localparam int IMM12_MSB = 11;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2,
        HALT  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mp_multicycle_core_alu.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mp_alu
// Purpose  : Combinational ALU: add/sub/and/or/xor/signed-slt/shift-by-one.
// Revision : 1.0 - initial release
// ============================================================================
module mp_alu
    import mp_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [2:0]        i_fn,
    output logic [DATA_W-1:0] o_result,
    output logic              o_zero
);

    always_comb begin
        o_result = '0;
        case (i_fn)
            FN_ADD: o_result = i_a + i_b;
            FN_SUB: o_result = i_a - i_b;
            FN_AND: o_result = i_a & i_b;
            FN_OR:  o_result = i_a | i_b;
            FN_XOR: o_result = i_a ^ i_b;
            FN_SLT: o_result = ($signed(i_a) < $signed(i_b)) ? DATA_W'(1) : '0;
            FN_SHL: o_result = {i_a[DATA_W-2:0], 1'b0};
            FN_SHR: o_result = {1'b0, i_a[DATA_W-1:1]};
            default: o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule
`default_nettype wire

// File: rtl/mp_multicycle_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mp_multicycle_core
// Purpose  : Multicycle MP core: FETCH/EXEC/MEM FSM, 8-entry register file,
//            req/ack data-memory port and registered board output.
// Revision : 1.0 - initial release
// ============================================================================
module mp_multicycle_core
    import mp_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int IN_W   = 4
) (
    input  logic              Clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    input  logic [IN_W-1:0]   Design_IN,
    output logic [DATA_W-1:0] Design_OUT,
    output logic              out_valid,
    output logic              halted
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_br_target;
    logic [15:0]       r_ir;
    logic [DATA_W-1:0] r_rf [8];
    logic [DATA_W-1:0] r_design_out;
    logic              r_out_valid;

    logic [3:0]        w_op;
    logic [2:0]        w_rs;
    logic [2:0]        w_rt;
    logic [2:0]        w_rd;
    logic [2:0]        w_fn;
    logic [5:0]        w_imm6;
    logic [11:0]       w_imm12;
    logic [DATA_W-1:0] w_imm_d;
    logic [ADDR_W-1:0] w_imm_a;
    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;

    logic [DATA_W-1:0] w_alu_b;
    logic [2:0]        w_alu_fn;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_alu_zero;

    logic              w_we;
    logic [2:0]        w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_out_load;

    assign w_op    = r_ir[OP_MSB:OP_LSB];
    assign w_rs    = r_ir[RS_MSB:RS_LSB];
    assign w_rt    = r_ir[RT_MSB:RT_LSB];
    assign w_rd    = r_ir[RD_MSB:RD_LSB];
    assign w_fn    = r_ir[FN_MSB:FN_LSB];
    assign w_imm6  = r_ir[IMM6_MSB:0];
    assign w_imm12 = r_ir[IMM12_MSB:0];
    assign w_imm_d = {{(DATA_W-6){w_imm6[5]}}, w_imm6};
    assign w_imm_a = {{(ADDR_W-6){w_imm6[5]}}, w_imm6};

    // r0 is hardwired to zero on both read ports
    assign w_rs_val = (w_rs == 3'd0) ? '0 : r_rf[w_rs];
    assign w_rt_val = (w_rt == 3'd0) ? '0 : r_rf[w_rt];

    assign w_pc_inc    = r_pc + ADDR_W'(1);
    assign w_br_target = w_pc_inc + w_imm_a;

    assign w_alu_b  = (w_op == OP_RALU || w_op == OP_BEQ || w_op == OP_BNE) ? w_rt_val : w_imm_d;
    assign w_alu_fn = (w_op == OP_RALU) ? w_fn :
                      (w_op == OP_BEQ || w_op == OP_BNE) ? FN_SUB : FN_ADD;

    mp_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_a      (w_rs_val),
        .i_b      (w_alu_b),
        .i_fn     (w_alu_fn),
        .o_result (w_alu_res),
        .o_zero   (w_alu_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_we        = 1'b0;
        w_waddr     = w_rt;
        w_wdata     = w_alu_res;
        w_out_load  = 1'b0;
        case (r_state)
            FETCH: w_state_nxt = EXEC;
            EXEC: begin
                w_state_nxt = FETCH;
                w_pc_nxt    = w_pc_inc;
                case (w_op)
                    OP_RALU: begin
                        w_we    = 1'b1;
                        w_waddr = w_rd;
                    end
                    OP_ADDI: w_we = 1'b1;
                    OP_LW, OP_SW: begin
                        w_state_nxt = MEM;
                        w_pc_nxt    = r_pc;
                    end
                    OP_BEQ: if (w_alu_zero)  w_pc_nxt = w_br_target;
                    OP_BNE: if (!w_alu_zero) w_pc_nxt = w_br_target;
                    OP_J:   w_pc_nxt = w_imm12[ADDR_W-1:0];
                    OP_JAL: begin
                        w_we     = 1'b1;
                        w_waddr  = LINK_REG;
                        w_wdata  = DATA_W'(w_pc_inc);
                        w_pc_nxt = w_imm12[ADDR_W-1:0];
                    end
                    OP_JR:  w_pc_nxt = ADDR_W'(w_rs_val);
                    OP_IN: begin
                        w_we    = 1'b1;
                        w_wdata = DATA_W'(Design_IN);
                    end
                    OP_OUT: w_out_load = 1'b1;
                    OP_HALT: begin
                        w_state_nxt = HALT;
                        w_pc_nxt    = r_pc;
                    end
                    default: w_pc_nxt = w_pc_inc;
                endcase
            end
            // PC stays on the load/store until the bus acknowledges it
            MEM: begin
                if (dmem_ack) begin
                    w_state_nxt = FETCH;
                    w_pc_nxt    = w_pc_inc;
                    if (w_op == OP_LW) begin
                        w_we    = 1'b1;
                        w_wdata = dmem_rdata;
                    end
                end
            end
            HALT: w_state_nxt = HALT;
            default: w_state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_state      <= FETCH;
            r_pc         <= '0;
            r_ir         <= '0;
            r_design_out <= '0;
            r_out_valid  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_out_valid <= w_out_load;
            if (r_state == FETCH) begin
                r_ir <= imem_rdata;
            end
            if (w_we && (w_waddr != 3'd0)) begin
                r_rf[w_waddr] <= w_wdata;
            end
            if (w_out_load) begin
                r_design_out <= w_rs_val;
            end
        end
    end

    assign imem_addr  = r_pc;
    assign dmem_req   = (r_state == MEM);
    assign dmem_we    = (w_op == OP_SW);
    assign dmem_addr  = ADDR_W'(w_alu_res);
    assign dmem_wdata = w_rt_val;
    assign Design_OUT = r_design_out;
    assign out_valid  = r_out_valid;
    assign halted     = (r_state == HALT);

endmodule
`default_nettype wire

// File: tb/tb_mp_multicycle_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mp_multicycle_core
// Purpose  : Directed self-checking bench for mp_multicycle_core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mp_multicycle_core;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;
    localparam int IN_W   = 4;

    logic              Clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_rdata;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;
    logic [IN_W-1:0]   Design_IN;
    logic [DATA_W-1:0] Design_OUT;
    logic              out_valid;
    logic              halted;

    logic [15:0]       imem [0:4095];
    logic [DATA_W-1:0] dmem [0:4095];
    logic [DATA_W-1:0] outq [$];

    int                total = 0;
    int                bad = 0;
    int                ack_dly = 3;
    int                acc_len = 0;
    int                acc_done = 0;
    logic              in_acc = 1'b0;
    logic              acc_stable = 1'b0;
    logic              acc_we = 1'b0;
    logic [ADDR_W-1:0] acc_addr = '0;
    logic [DATA_W-1:0] acc_wdata = '0;

    mp_multicycle_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .IN_W   (IN_W)
    ) dut (
        .Clk        (Clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .Design_IN  (Design_IN),
        .Design_OUT (Design_OUT),
        .out_valid  (out_valid),
        .halted     (halted)
    );

    always #5 Clk = ~Clk;

    assign imem_rdata = imem[imem_addr];

    function automatic logic [15:0] enc_r(input logic [2:0] rs, input logic [2:0] rt,
                                          input logic [2:0] rd, input logic [2:0] fn);
        return {4'h0, rs, rt, rd, fn};
    endfunction

    function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rs,
                                          input logic [2:0] rt, input logic [5:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [15:0] enc_j(input logic [3:0] op, input logic [11:0] imm);
        return {op, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_pc(input string tag, input logic [ADDR_W-1:0] a);
        int n = 0;
        while (imem_addr !== a && n < 300) begin
            @(negedge Clk);
            n++;
        end
        chk(tag, 32'(imem_addr), 32'(a));
    endtask

    task automatic wait_leave(input logic [ADDR_W-1:0] a);
        int n = 0;
        while (imem_addr === a && n < 50) begin
            @(negedge Clk);
            n++;
        end
    endtask

    task automatic wait_out(input string tag, input logic [DATA_W-1:0] exp);
        int n = 0;
        logic [DATA_W-1:0] v;
        v = 'x;
        while (outq.size() == 0 && n < 300) begin
            @(negedge Clk);
            n++;
        end
        if (outq.size() != 0) v = outq.pop_front();
        chk(tag, 32'(v), 32'(exp));
    endtask

    // Output capture and wait-stated data memory responder
    initial begin
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(negedge Clk);
            if (out_valid === 1'b1) outq.push_back(Design_OUT);
            if (dmem_req === 1'b1 && !reset) begin
                if (!in_acc) begin
                    in_acc     = 1'b1;
                    acc_len    = 0;
                    acc_stable = 1'b1;
                    acc_addr   = dmem_addr;
                    acc_wdata  = dmem_wdata;
                    acc_we     = dmem_we;
                end else if (dmem_addr !== acc_addr || dmem_wdata !== acc_wdata || dmem_we !== acc_we) begin
                    acc_stable = 1'b0;
                end
                acc_len++;
                if (acc_len == ack_dly + 1) begin
                    dmem_ack = 1'b1;
                    if (dmem_we) dmem[dmem_addr] = dmem_wdata;
                    else         dmem_rdata = dmem[dmem_addr];
                end else begin
                    dmem_ack = 1'b0;
                end
            end else begin
                if (in_acc) acc_done++;
                in_acc   = 1'b0;
                dmem_ack = 1'b0;
            end
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 4096; i++) begin
            imem[i] = 16'hC000;
            dmem[i] = '0;
        end
        imem[12'h000] = enc_i(4'h1, 3'd0, 3'd1, 6'd5);
        imem[12'h001] = enc_i(4'h1, 3'd0, 3'd2, 6'h3D);
        imem[12'h002] = enc_r(3'd1, 3'd2, 3'd3, 3'd0);
        imem[12'h003] = enc_i(4'hA, 3'd3, 3'd0, 6'd0);
        imem[12'h004] = enc_i(4'h3, 3'd0, 3'd1, 6'd4);
        imem[12'h005] = enc_i(4'h2, 3'd0, 3'd4, 6'd4);
        imem[12'h006] = enc_i(4'hA, 3'd4, 3'd0, 6'd0);
        imem[12'h007] = enc_j(4'h6, 12'h010);
        imem[12'h010] = enc_i(4'h4, 3'd0, 3'd0, 6'h3F);
        imem[12'h011] = enc_j(4'h6, 12'hFFF);
        imem[12'hFFF] = enc_i(4'h1, 3'd0, 3'd0, 6'd7);
        imem[12'h020] = enc_i(4'hA, 3'd7, 3'd0, 6'd0);
        imem[12'h021] = enc_i(4'h8, 3'd7, 3'd0, 6'd0);
        imem[12'h030] = enc_r(3'd1, 3'd2, 3'd3, 3'd4);
        imem[12'h031] = enc_i(4'hA, 3'd3, 3'd0, 6'd0);
        imem[12'h032] = enc_r(3'd2, 3'd5, 3'd3, 3'd2);
        imem[12'h033] = enc_i(4'hA, 3'd3, 3'd0, 6'd0);
        imem[12'h034] = enc_r(3'd5, 3'd1, 3'd3, 3'd3);
        imem[12'h035] = enc_i(4'hA, 3'd3, 3'd0, 6'd0);
        imem[12'h036] = enc_r(3'd5, 3'd0, 3'd3, 3'd6);
        imem[12'h037] = enc_i(4'hA, 3'd3, 3'd0, 6'd0);
        imem[12'h038] = enc_r(3'd1, 3'd2, 3'd3, 3'd5);
        imem[12'h039] = enc_i(4'hA, 3'd3, 3'd0, 6'd0);
        imem[12'h03A] = enc_r(3'd2, 3'd0, 3'd3, 3'd7);
        imem[12'h03B] = enc_i(4'hA, 3'd3, 3'd0, 6'd0);
        imem[12'h03C] = 16'hD000;
        imem[12'h03D] = 16'hB000;
        Design_IN = 4'hA;
        reset     = 1'b1;

        repeat (3) @(negedge Clk);
        chk("rst_pc", 32'(imem_addr), 32'h0);
        chk("rst_req", 32'(dmem_req), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_design_out", 32'(Design_OUT), 32'h0);
        reset = 1'b0;

        // ADDI, ADDI, ADD, OUT: output register loads at the end of cycle 8
        repeat (7) @(negedge Clk);
        chk("out_not_early", 32'(out_valid), 32'h0);
        @(negedge Clk);
        chk("out_pulse", 32'(out_valid), 32'h1);
        chk("out_add", 32'(Design_OUT), 32'h2);
        @(negedge Clk);
        chk("out_pulse_once", 32'(out_valid), 32'h0);
        wait_out("q_add", 16'h0002);

        // Store with three wait states, then load back
        n = 0;
        while (acc_done < 1 && n < 100) begin
            @(negedge Clk);
            n++;
        end
        chk("sw_req_len", 32'(acc_len), 32'd4);
        chk("sw_stable", 32'(acc_stable), 32'h1);
        chk("sw_addr", 32'(acc_addr), 32'h4);
        chk("sw_wdata", 32'(acc_wdata), 32'h5);
        chk("sw_we", 32'(acc_we), 32'h1);
        wait_out("lw_r4", 16'h0005);

        // BEQ r0,r0,-1 spins on itself
        wait_pc("reach_beq", 12'h010);
        repeat (10) @(negedge Clk);
        chk("beq_loop_pc", 32'(imem_addr), 32'h010);
        imem[12'h000] = enc_i(4'hA, 3'd0, 3'd0, 6'd0);
        imem[12'h001] = enc_j(4'h6, 12'h005);
        imem[12'h005] = enc_j(4'h7, 12'h020);
        imem[12'h006] = enc_i(4'h9, 3'd0, 3'd5, 6'd0);
        imem[12'h007] = enc_i(4'hA, 3'd5, 3'd0, 6'd0);
        imem[12'h008] = enc_i(4'h1, 3'd0, 3'd2, 6'h3F);
        imem[12'h009] = enc_i(4'h1, 3'd0, 3'd1, 6'd1);
        imem[12'h00A] = enc_r(3'd2, 3'd1, 3'd6, 3'd5);
        imem[12'h00B] = enc_i(4'hA, 3'd6, 3'd0, 6'd0);
        imem[12'h00C] = enc_r(3'd1, 3'd2, 3'd3, 3'd1);
        imem[12'h00D] = enc_i(4'hA, 3'd3, 3'd0, 6'd0);
        imem[12'h00E] = enc_j(4'h6, 12'h030);
        imem[12'h010] = enc_i(4'h5, 3'd1, 3'd1, 6'd5);
        wait_leave(12'h010);
        chk("bne_not_taken", 32'(imem_addr), 32'h011);

        wait_pc("reach_top", 12'hFFF);
        wait_leave(12'hFFF);
        chk("pc_wrap", 32'(imem_addr), 32'h000);
        wait_out("r0_reads_zero", 16'h0000);

        wait_pc("reach_jal", 12'h005);
        wait_leave(12'h005);
        chk("jal_target", 32'(imem_addr), 32'h020);
        wait_out("jal_link", 16'h0006);
        wait_pc("reach_jr", 12'h021);
        wait_leave(12'h021);
        chk("jr_target", 32'(imem_addr), 32'h006);

        wait_out("in_port", 16'h000A);
        wait_out("slt_neg_pos", 16'h0001);
        wait_out("sub", 16'h0002);
        wait_out("xor", 16'hFFFE);
        wait_out("and", 16'h000A);
        wait_out("or", 16'h000B);
        wait_out("shl", 16'h0014);
        wait_out("slt_pos_neg", 16'h0000);
        wait_out("shr", 16'h7FFF);

        n = 0;
        while (halted !== 1'b1 && n < 100) begin
            @(negedge Clk);
            n++;
        end
        chk("halted", 32'(halted), 32'h1);
        chk("halt_pc", 32'(imem_addr), 32'h03D);
        repeat (10) @(negedge Clk);
        chk("halt_pc_frozen", 32'(imem_addr), 32'h03D);
        chk("halt_still", 32'(halted), 32'h1);
        chk("halt_no_req", 32'(dmem_req), 32'h0);

        // Restart, then reset while a store is stalled waiting for ack
        imem[12'h000] = enc_i(4'h1, 3'd0, 3'd1, 6'd9);
        imem[12'h001] = enc_i(4'hA, 3'd1, 3'd0, 6'd0);
        imem[12'h002] = enc_i(4'h3, 3'd0, 3'd1, 6'd4);
        ack_dly = 1000;
        reset   = 1'b1;
        @(negedge Clk);
        chk("halt_cleared", 32'(halted), 32'h0);
        reset = 1'b0;
        wait_out("pre_reset_out", 16'h0009);
        n = 0;
        while (dmem_req !== 1'b1 && n < 50) begin
            @(negedge Clk);
            n++;
        end
        chk("stall_req", 32'(dmem_req), 32'h1);
        repeat (2) @(negedge Clk);
        chk("stall_pc", 32'(imem_addr), 32'h002);
        reset = 1'b1;
        #1;
        chk("rst_drops_req", 32'(dmem_req), 32'h0);
        chk("rst_pc_async", 32'(imem_addr), 32'h0);
        @(negedge Clk);
        reset = 1'b0;
        chk("post_rst_out", 32'(Design_OUT), 32'h0);
        chk("post_rst_valid", 32'(out_valid), 32'h0);
        chk("post_rst_pc", 32'(imem_addr), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
